// File: rtl/apb_reg_slave_pkg.sv
// Shared types and register map constants for the APB register completer.
package apb_reg_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int ID_IDX   = 0;
    localparam int WAIT_IDX = 1;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/apb_reg_slave_wait_cnt.sv
// Loadable wait-state down-counter; o_last flags the final wait cycle. Used only with APB_REG_SLAVE_WAIT_EN.
// Loads in one cycle, decrements once per enabled cycle, never wraps below zero.
module apb_reg_slave_wait_cnt
    import apb_reg_slave_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_last
);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == WAIT_W'(1));

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with ID, WAIT_CFG and general registers; registered PREADY/PRDATA/PSLVERR, transfer = 2 + WAIT_CFG cycles.
// Macro APB_REG_SLAVE_WAIT_EN adds WAIT_CFG and programmable wait states; without it every transfer is 2 cycles.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        NUM_REGS       = 8,
    parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE       = 32'hA5B0_0001
)(
    input  logic                               PCLK,
    input  logic                               PRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
    input  logic                               PWRITE,
    input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
    input  logic                               PSEL,
    input  logic                               PENABLE,
    output logic                               PREADY,
    output logic [APB_DATA_WIDTH-1:0]          PRDATA,
    output logic                               PSLVERR,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                reg_wr_stb
);

    localparam int               IDX_W      = APB_ADDR_WIDTH - 2;
    localparam logic [IDX_W:0]   NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx;
    logic [IDX_W-1:0]          w_rd_idx;
    logic                      r_write;
    logic                      r_err;
    logic                      w_err;
    logic                      w_setup;
    logic                      w_to_ready;
    logic                      w_ready_err;
    logic                      w_commit;
    logic                      w_wait_zero;
    logic                      w_cnt_last;
    logic [APB_DATA_WIDTH-1:0] w_rdata;
    logic [NUM_REGS-1:0]       w_stb;
    logic [APB_DATA_WIDTH-1:0] r_gen [2:NUM_REGS-1];
    logic                      r_pready;
    logic                      r_pslverr;
    logic [APB_DATA_WIDTH-1:0] r_prdata;
    logic [NUM_REGS-1:0]       r_wr_stb;

    assign w_idx   = PADDR[APB_ADDR_WIDTH-1:2];
    assign w_setup = PSEL && !PENABLE;
    assign w_err   = (PADDR[1:0] != 2'b00)
                   || ({1'b0, w_idx} >= NUM_REGS_L)
                   || (PWRITE && (w_idx == IDX_W'(ID_IDX)));

    // With zero wait states READY is entered on the setup edge itself, before the decode is latched.
    assign w_rd_idx    = (r_state == IDLE) ? w_idx : r_idx;
    assign w_ready_err = (r_state == IDLE) ? w_err : r_err;
    assign w_commit    = (r_state == READY) && PSEL && PENABLE && r_write && !r_err;

`ifdef APB_REG_SLAVE_WAIT_EN
    logic [WAIT_W-1:0] r_wait_cfg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cfg <= '0;
        end else if (w_stb[WAIT_IDX]) begin
            r_wait_cfg <= PWDATA[WAIT_W-1:0];
        end
    end

    assign w_wait_zero = (r_wait_cfg == '0);

    apb_reg_slave_wait_cnt u_wait_cnt (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_load     ((r_state == IDLE) && w_setup),
        .i_load_val (r_wait_cfg),
        .i_dec      ((r_state == WAIT) && PSEL),
        .o_last     (w_cnt_last)
    );
`else
    assign w_wait_zero = 1'b1;
    assign w_cnt_last  = 1'b1;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_rd_idx == IDX_W'(ID_IDX)) begin
            w_rdata = ID_VALUE;
        end
`ifdef APB_REG_SLAVE_WAIT_EN
        if (w_rd_idx == IDX_W'(WAIT_IDX)) begin
            w_rdata[WAIT_W-1:0] = r_wait_cfg;
        end
`endif
        for (int i = 2; i < NUM_REGS; i++) begin
            if (w_rd_idx == IDX_W'(i)) begin
                w_rdata = r_gen[i];
            end
        end
    end

    always_comb begin
        w_stb = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_stb[i] = w_commit && (r_idx == IDX_W'(i));
        end
`ifndef APB_REG_SLAVE_WAIT_EN
        // Writes to the absent WAIT_CFG complete without error but change nothing.
        w_stb[WAIT_IDX] = 1'b0;
`endif
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                r_gen[i] <= '0;
            end
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (w_stb[i]) begin
                    r_gen[i] <= PWDATA;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_to_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    if (w_wait_zero) begin
                        w_next_state = READY;
                        w_to_ready   = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    w_next_state = IDLE;
                end else if (w_cnt_last) begin
                    w_next_state = READY;
                    w_to_ready   = 1'b1;
                end
            end
            READY:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_wr_stb  <= '0;
        end else begin
            if ((r_state == IDLE) && w_setup) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_err   <= w_err;
            end
            r_pready  <= w_to_ready;
            r_pslverr <= w_to_ready && w_ready_err;
            r_prdata  <= (w_to_ready && !w_ready_err) ? w_rdata : '0;
            r_wr_stb  <= w_stb;
        end
    end

    always_comb begin
        reg_q = '0;
        reg_q[ID_IDX*APB_DATA_WIDTH +: APB_DATA_WIDTH] = ID_VALUE;
`ifdef APB_REG_SLAVE_WAIT_EN
        reg_q[WAIT_IDX*APB_DATA_WIDTH +: WAIT_W] = r_wait_cfg;
`endif
        for (int i = 2; i < NUM_REGS; i++) begin
            reg_q[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] = r_gen[i];
        end
    end

    assign PREADY     = r_pready;
    assign PSLVERR    = r_pslverr;
    assign PRDATA     = r_prdata;
    assign reg_wr_stb = r_wr_stb;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized bench for apb_reg_slave checked against a transaction-level register model.
// Honours APB_REG_SLAVE_WAIT_EN so the same bench covers both builds.
module tb_apb_reg_slave;

    localparam int          AW     = 12;
    localparam int          DW     = 32;
    localparam int          NR     = 8;
    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;
`ifdef APB_REG_SLAVE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [AW-1:0]    PADDR;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic             PSEL;
    logic             PENABLE;
    logic             PREADY;
    logic [DW-1:0]    PRDATA;
    logic             PSLVERR;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_wr_stb;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_regs [NR];
    int          m_wait;

    always #5 PCLK = ~PCLK;

    apb_reg_slave #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .NUM_REGS       (NR),
        .ID_VALUE       (ID_VAL)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        m_wait = 0;
    endfunction

    function automatic bit model_err(input logic wr, input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr >> 2);
        return (addr[1:0] != 2'b00) || (idx >= NR) || (wr && (idx == 0));
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        if (idx == 0) return ID_VAL;
        if (idx == 1) return WAIT_EN ? 32'(m_wait) : 32'h0;
        return m_regs[idx];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 1; i < NR; i++)
            check_eq($sformatf("%s/reg_q[%0d]", tag, i), reg_q[i*DW +: DW], model_word(i));
    endtask

    // Full APB transfer; entered and left 1 time unit after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cycles,
                            output logic [NR-1:0] stb);
        int n;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 1;
        while (!PREADY && (n < 40)) begin
            @(posedge PCLK); #1;
            n++;
        end
        cycles = 1 + n;
        rdata  = PRDATA;
        err    = PSLVERR;
        @(posedge PCLK); #1;
        stb     = reg_wr_stb;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
        logic [31:0]   rdata;
        logic          err;
        int            cycles;
        logic [NR-1:0] stb;
        bit            exp_err;
        int            idx;
        int            exp_cycles;
        logic [31:0]   exp_rd;
        logic [NR-1:0] exp_stb;
        exp_err    = model_err(wr, addr);
        idx        = int'(addr >> 2);
        exp_cycles = 2 + m_wait;
        exp_rd     = 32'h0;
        if (!exp_err) exp_rd = model_word(idx);
        exp_stb    = '0;
        apb_xfer(wr, addr, wdata, rdata, err, cycles, stb);
        check_eq($sformatf("%s/cycles", tag), 32'(cycles), 32'(exp_cycles));
        check_eq($sformatf("%s/pslverr", tag), {31'b0, err}, {31'b0, exp_err});
        if (!wr || exp_err) check_eq($sformatf("%s/prdata", tag), rdata, exp_rd);
        if (wr && !exp_err) begin
            if (idx == 1) begin
                if (WAIT_EN) begin
                    m_wait     = int'(wdata[3:0]);
                    exp_stb[1] = 1'b1;
                end
            end else begin
                m_regs[idx]  = wdata;
                exp_stb[idx] = 1'b1;
            end
        end
        check_eq($sformatf("%s/stb", tag), 32'(stb), 32'(exp_stb));
        check_regs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [AW-1:0] a;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("rst/pready", {31'b0, PREADY}, 32'h0);
        check_eq("rst/pslverr", {31'b0, PSLVERR}, 32'h0);
        check_eq("rst/prdata", PRDATA, 32'h0);
        check_eq("rst/stb", 32'(reg_wr_stb), 32'h0);
        check_regs("rst");
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        do_xfer("id_rd", 1'b0, 12'h000, 32'h0);
        do_xfer("wr8", 1'b1, 12'h008, 32'hDEAD_BEEF);
        @(posedge PCLK); #1;
        check_eq("wr8/stb_drop", 32'(reg_wr_stb), 32'h0);
        do_xfer("rd8", 1'b0, 12'h008, 32'h0);
        do_xfer("cfg3", 1'b1, 12'h004, 32'h0000_0003);
        do_xfer("rd8_w3", 1'b0, 12'h008, 32'h0);
        do_xfer("cfg15", 1'b1, 12'h004, 32'hFFFF_FFFF);
        do_xfer("rd_cfg", 1'b0, 12'h004, 32'h0);
        do_xfer("rd8_w15", 1'b0, 12'h008, 32'h0);
        do_xfer("cfg5", 1'b1, 12'h004, 32'h0000_0005);
        do_xfer("err_wr_id", 1'b1, 12'h000, 32'h1234_5678);
        do_xfer("err_rd_oor", 1'b0, 12'h020, 32'h0);
        do_xfer("err_wr_mis", 1'b1, 12'h00A, 32'hCAFE_F00D);
        do_xfer("cfg3b", 1'b1, 12'h004, 32'h0000_0003);
        do_xfer("wr_c", 1'b1, 12'h00C, 32'h1111_2222);

        // Abort: PSEL drops in the first access cycle of a write to 0x00C.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'hBAD0_0BAD;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        @(posedge PCLK); #1;
        check_eq("abort/pready", {31'b0, PREADY}, 32'h0);
        check_eq("abort/prdata", PRDATA, 32'h0);
        @(posedge PCLK); #1;
        check_eq("abort/stb", 32'(reg_wr_stb), 32'h0);
        check_regs("abort");
        do_xfer("after_abort", 1'b0, 12'h00C, 32'h0);

        // Reset asserted in the first access cycle of a write.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h010; PWDATA = 32'h5555_AAAA;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mid/pready", {31'b0, PREADY}, 32'h0);
        check_eq("rst_mid/pslverr", {31'b0, PSLVERR}, 32'h0);
        check_eq("rst_mid/prdata", PRDATA, 32'h0);
        check_eq("rst_mid/stb", 32'(reg_wr_stb), 32'h0);
        check_regs("rst_mid");
        PSEL = 1'b0; PENABLE = 1'b0;
        #3;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        do_xfer("post_rst", 1'b0, 12'h010, 32'h0);
        do_xfer("cfg_wr5", 1'b1, 12'h004, 32'h0000_0005);
        do_xfer("cfg_rd5", 1'b0, 12'h004, 32'h0);

        for (int t = 0; t < 150; t++) begin
            a = AW'($urandom_range(0, 11) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, $urandom);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(posedge PCLK);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

Synthesizable APB3 completer that terminates the APB bus driven by the codebase's master (`apb_if.master_mp` BFM or converter RTL). It contains a small word-addressed register bank and a read-only ID register. It inserts a programmable number of wait states and flags illegal accesses with PSLVERR. Its outputs are the general registers and per-register write strobes, which feed downstream control logic.

## Interface
- APB_ADDR_WIDTH, 12, PADDR width; byte address.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width.
- NUM_REGS, 8, number of word registers; must be ≥3 and ≤ 2^(APB_ADDR_WIDTH-2).
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  APB_DATA_WIDTH  write data.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PREADY  out  1  transfer completes this cycle; registered.
- PRDATA  out  APB_DATA_WIDTH  read data; valid while PREADY=1; registered.
- PSLVERR  out  1  error response; valid while PREADY=1; registered.
- reg_q  out  NUM_REGS*APB_DATA_WIDTH  flattened register contents; word i at [i*W +: W].
- reg_wr_stb  out  NUM_REGS  one-cycle pulse per committed register write.

## Operation
- Register index is PADDR[APB_ADDR_WIDTH-1:2].
- Register 0 is ID: read-only and returns ID_VALUE.
- Register 1 is WAIT_CFG: bits [3:0] are RW and set the wait count; bits [31:4] read 0.
- Registers 2..NUM_REGS-1 are general RW.
- Error conditions, giving PSLVERR=1:
  - PADDR[1:0]≠0;
  - index ≥ NUM_REGS;
  - a write to register 0.
- On error: no register changes, no strobe fires, PRDATA=0.
- FSM states are IDLE, WAIT and READY.
  - IDLE: on an edge with PSEL=1 and PENABLE=0 (setup), latch the address, direction and decode result, and load cnt = WAIT_CFG[3:0]. If cnt=0, go to READY. Otherwise go to WAIT.
  - WAIT: decrement cnt each edge. When cnt=1, go to READY.
  - On every transition into READY, register PREADY=1, PSLVERR=err and PRDATA=read data. Read data is sampled at this edge.
  - READY: at the next edge (the completion edge, where PSEL=PENABLE=PREADY=1), commit the write if it is legal. Then clear PREADY, PSLVERR and PRDATA to 0 and return to IDLE.
- Write commit: reg[idx] ← PWDATA. For WAIT_CFG only bits [3:0] are stored. reg_wr_stb[idx] pulses high for the cycle after the completion edge.
- A new WAIT_CFG value applies from the next transfer's setup edge onward.
- PSEL=0 in WAIT or READY (protocol abort): return to IDLE, clear all outputs, commit no write.
- Back-to-back transfers are supported. A setup in the cycle after completion is accepted because the FSM is in IDLE at that edge.
- Reset, including mid-transfer, forces the following immediately and asynchronously:
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - reg_wr_stb=0;
  - all registers 0, so WAIT_CFG=0;
  - FSM in IDLE;
  - no partial write survives.

## Timing
- Transfer length is 2+N cycles, where N = WAIT_CFG: one setup cycle, N access cycles with PREADY=0, then one access cycle with PREADY=1.
- N=0: PREADY is high in the first access cycle.
- N=15 (maximum): 17 cycles.
- reg_q reflects a write one cycle after the completion edge, coincident with reg_wr_stb.

## Configuration
- Macro: APB_REG_SLAVE_WAIT_EN.
- Defined: WAIT_CFG and the wait counter are present, and behaviour is as above.
- Undefined:
  - register 1 reads 0, and writes to it are accepted without error and ignored;
  - no WAIT state and no counter;
  - every transfer is 2 cycles.

## Structure
- Package apb_reg_slave_pkg holds:
  - typedef enum state_t {IDLE, WAIT, READY};
  - localparams ID_IDX=0, WAIT_IDX=1, WAIT_W=4.
- One sub-module, apb_reg_slave_wait_cnt:
  - a loadable down-counter with a `last` flag;
  - instantiated only under APB_REG_SLAVE_WAIT_EN.

## Test plan
- Reset then read 0x000: PRDATA=0xA5B0_0001, PSLVERR=0, transfer 2 cycles.
- Write 0x008=0xDEAD_BEEF then read 0x008: data matches, reg_wr_stb[2] pulses once, reg_q word 2 = 0xDEAD_BEEF.
- Write 0x004=3, then read 0x008: PREADY low for 3 access cycles, 5-cycle transfer. Repeat with WAIT_CFG=15: 17 cycles.
- Error cases all give PSLVERR=1, no strobe and no register change:
  - write 0x000;
  - read 0x020 with NUM_REGS=8 (PRDATA=0);
  - write 0x00A.
- Abort and reset mid-transfer:
  - deassert PSEL during WAIT of a write to 0x00C: no commit, returns to IDLE;
  - assert PRESETn=0 during WAIT: outputs 0 immediately, WAIT_CFG=0, next transfer 2 cycles.
- Build without APB_REG_SLAVE_WAIT_EN: write 0x004=5 gives no error; read 0x004 returns 0; all transfers 2 cycles.
